// File: rtl/serial_adder32_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder32_ctrl
//   Multi-cycle WIDTH-bit add/subtract sequencer. It drives one shared external
//   SLICE-bit adder with one nibble per cycle, least significant first. The
//   carry is chained through a register between nibbles. The result and the
//   flags are returned over a valid/ready handshake.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   InValid/InReady     request handshake; A, B, Sub are sampled on accept
//   Flush               synchronous abort of the current operation
//   SliceIn1/2, SliceCI drive to the external slice (0 when not in RUN)
//   SliceOut, SliceCO   combinational response of the external slice
//   OutValid/OutReady   result handshake
//   Out, CO, OV, Z      result, carry (for Sub: 1 = no borrow), overflow, zero
// ---------------------------------------------------------------------------
module serial_adder32_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Flush,
    output logic [SLICE-1:0] SliceIn1,
    output logic [SLICE-1:0] SliceIn2,
    output logic             SliceCI,
    input  logic [SLICE-1:0] SliceOut,
    input  logic             SliceCO,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic             CO,
    output logic             OV,
    output logic             Z
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, bx_q, out_q, assembled;
    logic [IW-1:0]    idx;
    logic             carry, co_q, ov_q, z_q;
    logic             accept, step, last, clr;

    assign last = (idx == LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next state, handshake and slice drive
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        InReady  = 1'b0;
        OutValid = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        clr      = 1'b0;
        SliceIn1 = '0;
        SliceIn2 = '0;
        SliceCI  = 1'b0;
        case (state)
            IDLE: begin
                // The state is already IDLE while reset is held. Gating with
                // RST keeps the controller from advertising readiness then.
                InReady = ~RST;
                // Flush has priority over a request.
                if (InValid && !Flush) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                SliceIn1 = a_q[idx*SLICE +: SLICE];
                SliceIn2 = bx_q[idx*SLICE +: SLICE];
                SliceCI  = carry;
                if (Flush) begin
                    clr      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) state_nx = DONE;
                end
            end
            DONE: begin
                OutValid = 1'b1;
                if (Flush) begin
                    clr      = 1'b1;
                    state_nx = IDLE;
                end else if (OutReady) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // This is the result as it will look after the current nibble is written.
    // The zero flag is computed from it on the final edge, so the last nibble
    // is included.
    always_comb begin
        assembled = out_q;
        assembled[idx*SLICE +: SLICE] = SliceOut;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q   <= '0;
            bx_q  <= '0;
            out_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
            z_q   <= 1'b0;
        end else if (clr) begin
            out_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
            z_q   <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1. The +1 enters as the initial carry.
            a_q   <= A;
            bx_q  <= Sub ? ~B : B;
            carry <= Sub;
            idx   <= '0;
        end else if (step) begin
            out_q <= assembled;
            carry <= SliceCO;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                co_q <= SliceCO;
                ov_q <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                        (SliceOut[SLICE-1] != a_q[WIDTH-1]);
                z_q  <= (assembled == '0);
            end
        end
    end

    assign Out = out_q;
    assign CO  = co_q;
    assign OV  = ov_q;
    assign Z   = z_q;

endmodule

// File: tb/tb_serial_adder32_ctrl.sv
module tb_serial_adder32_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        InValid = 1'b0, InReady;
    logic [31:0] A = '0, B = '0;
    logic        Sub = 1'b0, Flush = 1'b0;
    logic [3:0]  SliceIn1, SliceIn2, SliceOut;
    logic        SliceCI, SliceCO;
    logic        OutValid, OutReady = 1'b0;
    logic [31:0] Out;
    logic        CO, OV, Z;
    logic [4:0]  slice_sum;

    int ntests = 0;
    int nfail  = 0;
    bit ci_log [8];

    always #5 CLK = ~CLK;

    // This is the external 4-bit adder slice.
    assign slice_sum = 5'(SliceIn1) + 5'(SliceIn2) + 5'(SliceCI);
    assign SliceOut  = slice_sum[3:0];
    assign SliceCO   = slice_sum[4];

    serial_adder32_ctrl dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Sub(Sub), .Flush(Flush),
        .SliceIn1(SliceIn1), .SliceIn2(SliceIn2), .SliceCI(SliceCI),
        .SliceOut(SliceOut), .SliceCO(SliceCO),
        .OutValid(OutValid), .OutReady(OutReady),
        .Out(Out), .CO(CO), .OV(OV), .Z(Z)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // This is the reference model: full-width arithmetic, returned as {co, ov, z, res}.
    function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] sum;
        logic [31:0] res;
        logic        co, ov;
        if (s) begin
            res = a - b;
            co  = (a >= b);
            ov  = (a[31] != b[31]) && (res[31] != a[31]);
        end else begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[31:0];
            co  = sum[32];
            ov  = (a[31] == b[31]) && (res[31] != a[31]);
        end
        return {co, ov, (res == 32'd0), res};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        A = a; B = b; Sub = s; InValid = 1'b1;
        tick();
        InValid = 1'b0;
    endtask

    // This task runs one full operation. It checks the latency, the result and the
    // flags, and their stability while OutReady is held low for `hold` cycles.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        logic [34:0] e;
        int cnt;
        e = ref_model(a, b, s);
        chk({tag, ".inready"}, InReady, 1);
        start(a, b, s);
        // Operands change right after acceptance and must be ignored.
        A = $urandom; B = $urandom; Sub = 1'($urandom);
        cnt = 0;
        while (!OutValid && cnt < 40) begin
            if (cnt < 8) ci_log[cnt] = SliceCI;
            tick();
            cnt++;
        end
        chk({tag, ".lat"}, cnt, 8);
        if (!OutValid) return;
        for (int h = 0; h < hold; h++) begin
            chk({tag, ".hold_out"}, {Out, CO, OV, Z}, {e[31:0], e[34], e[33], e[32]});
            chk({tag, ".hold_rdy"}, {InReady, OutValid, SliceIn1, SliceIn2, SliceCI}, {2'b01, 9'd0});
            InValid = 1'($urandom); A = $urandom;
            tick();
        end
        InValid = 1'b0;
        chk({tag, ".out"}, Out, e[31:0]);
        chk({tag, ".flags"}, {CO, OV, Z}, e[34:32]);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        chk({tag, ".drop"}, {OutValid, InReady}, 2'b01);
        chk({tag, ".keep"}, Out, e[31:0]);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (OutValid) seen++;
            tick();
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst.inready", InReady, 0);
        chk("rst.outs", {OutValid, Out, CO, OV, Z}, 36'd0);
        chk("rst.slice", {SliceIn1, SliceIn2, SliceCI}, 9'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst.release", InReady, 1);
        tick();

        // Directed cases
        run_op("add_wrap", 32'h00000001, 32'hFFFFFFFF, 1'b0, 0);
        chk("add_wrap.z", {Out, CO, OV, Z}, {32'h0, 3'b101});
        run_op("add_ov", 32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        chk("add_ov.res", {Out, CO, OV, Z}, {32'h80000000, 3'b010});
        chk("add_ov.ci0", ci_log[0], 0);
        for (int i = 1; i < 8; i++) chk($sformatf("add_ov.ci%0d", i), ci_log[i], 1);
        run_op("sub_neg", 32'd5, 32'd7, 1'b1, 0);
        chk("sub_neg.res", {Out, CO, OV}, {32'hFFFFFFFE, 2'b00});
        chk("sub_neg.ci0", ci_log[0], 1);
        run_op("sub_ov", 32'h80000000, 32'd1, 1'b1, 0);
        chk("sub_ov.res", {Out, CO, OV}, {32'h7FFFFFFF, 2'b11});

        // Backpressure
        run_op("bp", 32'hDEADBEEF, 32'h01234567, 1'b0, 5);
        run_op("bp_next", 32'h00000010, 32'h00000020, 1'b1, 0);

        // Reset pulse while the operation is at index 3
        start(32'hFFFF0000, 32'h0000FFFF, 1'b0);
        repeat (3) tick();
        RST = 1'b1;
        #1;
        chk("rst_mid.outs", {OutValid, Out, CO, OV, Z}, 36'd0);
        chk("rst_mid.inready", InReady, 0);
        chk("rst_mid.slice", {SliceIn1, SliceIn2, SliceCI}, 9'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_mid.idle", InReady, 1);
        tick();
        run_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1);
        chk("post_rst.res", {Out, CO}, {32'h23456789, 1'b0});

        // Flush while the operation is at index 5
        start(32'h0F0F0F0F, 32'h01010101, 1'b0);
        repeat (5) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush_run.st", {OutValid, InReady}, 2'b01);
        chk("flush_run.out", {Out, CO, OV, Z}, 35'd0);
        watch_no_valid("flush_run.nov", 12);

        // Flush together with InValid in IDLE
        A = 32'h1; B = 32'h2; InValid = 1'b1; Flush = 1'b1;
        tick();
        InValid = 1'b0; Flush = 1'b0;
        chk("flush_idle.rdy", InReady, 1);
        watch_no_valid("flush_idle.nov", 12);
        run_op("post_flush", 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 0);

        // Flush in DONE
        start(32'h11111111, 32'h22222222, 1'b0);
        repeat (8) tick();
        chk("flush_done.valid", OutValid, 1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush_done.st", {OutValid, InReady, Out, CO, OV, Z}, {2'b01, 35'd0});

        // Random operations, with edge operands mixed in
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
